// File: rtl/amba_axi4_stream_seda_pkg.sv
// rtl/amba_axi4_stream_seda_pkg.sv - AXI4-Stream payload types and arbiter config shared by the stream blocks
package amba_axi4_stream_seda_pkg;

  typedef logic [31:0] axi_data_t;
  typedef logic [3:0]  axi_strb_t;
  typedef logic [3:0]  axi_keep_t;
  typedef logic [3:0]  axi_id_t;
  typedef logic [3:0]  axi_dest_t;
  typedef logic [3:0]  axi_user_t;

  localparam int AXI4_STREAM_NUM_SRC      = 4;
  localparam bit AXI4_STREAM_ARB_ON_TLAST = 1'b1;

  typedef enum logic {ARB_IDLE, ARB_BUSY} axi_arb_state_t;

endpackage

// File: rtl/amba_axi4_stream_rr_picker.sv
// rtl/amba_axi4_stream_rr_picker.sv - combinational round-robin pick: rotate by pointer, priority-encode, unrotate
module amba_axi4_stream_rr_picker #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  always_comb begin
    rot     = N'({req_i, req_i} >> ptr_i);
    found_o = |rot;
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    // N need not be a power of two, so unrotate with an explicit modulo
    sum = {1'b0, off} + {1'b0, ptr_i};
    if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
    idx_o = sum[W-1:0];
  end

endmodule

// File: rtl/amba_axi4_stream_rr_arbiter.sv
// rtl/amba_axi4_stream_rr_arbiter.sv - packet-level round-robin arbiter sharing one AXI4-Stream master port
module amba_axi4_stream_rr_arbiter
  import amba_axi4_stream_seda_pkg::*;
#(
  parameter  int NUM_SRC      = AXI4_STREAM_NUM_SRC,
  parameter  bit ARB_ON_TLAST = AXI4_STREAM_ARB_ON_TLAST,
  localparam int SRC_W        = $clog2(NUM_SRC)
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [NUM_SRC-1:0] s_tvalid,
  output logic [NUM_SRC-1:0] s_tready,
  input  axi_data_t          s_tdata [NUM_SRC],
  input  axi_strb_t          s_tstrb [NUM_SRC],
  input  axi_keep_t          s_tkeep [NUM_SRC],
  input  logic [NUM_SRC-1:0] s_tlast,
  input  axi_id_t            s_tid   [NUM_SRC],
  input  axi_dest_t          s_tdest [NUM_SRC],
  input  axi_user_t          s_tuser [NUM_SRC],
  output logic               m_tvalid,
  input  logic               m_tready,
  output axi_data_t          m_tdata,
  output axi_strb_t          m_tstrb,
  output axi_keep_t          m_tkeep,
  output logic               m_tlast,
  output axi_id_t            m_tid,
  output axi_dest_t          m_tdest,
  output axi_user_t          m_tuser,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               busy
);

  axi_arb_state_t   state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pick_found;
  logic [SRC_W-1:0] pick_idx;
  logic             release_grant;

  amba_axi4_stream_rr_picker #(.N(NUM_SRC)) u_picker (
    .req_i   (s_tvalid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // The grant is released on the accepted beat that ends the arbitration unit
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    release_grant = s_tvalid[grant_q] & m_tready & (s_tlast[grant_q] | !ARB_ON_TLAST);
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (release_grant) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ARB_BUSY);
    grant_idx = grant_q;
    m_tvalid  = busy & s_tvalid[grant_q];
    s_tready  = '0;
    if (busy) s_tready[grant_q] = m_tready;
    m_tdata   = s_tdata[grant_q];
    m_tstrb   = s_tstrb[grant_q];
    m_tkeep   = s_tkeep[grant_q];
    m_tlast   = s_tlast[grant_q];
    m_tid     = s_tid[grant_q];
    m_tdest   = s_tdest[grant_q];
    m_tuser   = s_tuser[grant_q];
  end

endmodule

// File: tb/tb_amba_axi4_stream_rr_arbiter.sv
// tb/tb_amba_axi4_stream_rr_arbiter.sv - directed vector bench for the packet round-robin arbiter
module tb_amba_axi4_stream_rr_arbiter;
  import amba_axi4_stream_seda_pkg::*;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [3:0] s_tvalid = '0;
  logic [3:0] s_tready, s2_tready;
  axi_data_t  s_tdata [4];
  axi_strb_t  s_tstrb [4];
  axi_keep_t  s_tkeep [4];
  logic [3:0] s_tlast = '0;
  axi_id_t    s_tid   [4];
  axi_dest_t  s_tdest [4];
  axi_user_t  s_tuser [4];
  logic       m_tvalid, m2_tvalid;
  logic       m_tready = 1'b1;
  axi_data_t  m_tdata, m2_tdata;
  axi_strb_t  m_tstrb, m2_tstrb;
  axi_keep_t  m_tkeep, m2_tkeep;
  logic       m_tlast, m2_tlast;
  axi_id_t    m_tid, m2_tid;
  axi_dest_t  m_tdest, m2_tdest;
  axi_user_t  m_tuser, m2_tuser;
  logic [1:0] grant_idx, grant2_idx;
  logic       busy, busy2;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  amba_axi4_stream_rr_arbiter #(.NUM_SRC(4), .ARB_ON_TLAST(1'b1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant_idx(grant_idx), .busy(busy)
  );

  amba_axi4_stream_rr_arbiter #(.NUM_SRC(4), .ARB_ON_TLAST(1'b0)) dut2 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid), .s_tready(s2_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m2_tvalid), .m_tready(m_tready), .m_tdata(m2_tdata), .m_tstrb(m2_tstrb),
    .m_tkeep(m2_tkeep), .m_tlast(m2_tlast), .m_tid(m2_tid), .m_tdest(m2_tdest), .m_tuser(m2_tuser),
    .grant_idx(grant2_idx), .busy(busy2)
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] last;
    logic       mrdy;
    logic [7:0] dat;
    logic       e_mv;
    logic [3:0] e_srdy;
    logic [1:0] e_gnt;
    logic       e_busy;
    logic       e_last;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] last,
                     input logic mrdy, input logic [7:0] dat, input logic e_mv,
                     input logic [3:0] e_srdy, input logic [1:0] e_gnt,
                     input logic e_busy, input logic e_last);
    vec_t v;
    v.rst = rst; v.vld = vld; v.last = last; v.mrdy = mrdy; v.dat = dat;
    v.e_mv = e_mv; v.e_srdy = e_srdy; v.e_gnt = e_gnt; v.e_busy = e_busy; v.e_last = e_last;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] vld, input logic [3:0] last,
                       input logic mrdy, input logic [7:0] dat);
    ARESETn  = ~rst;
    s_tvalid = vld;
    s_tlast  = last;
    m_tready = mrdy;
    for (int i = 0; i < 4; i++) s_tdata[i] = {16'h0, 8'(i), dat};
  endtask

  // Driven just after the falling edge, checked 1 ns later, state advances at the next rising edge
  task automatic run_vec(input vec_t v, input int idx);
    drive(v.rst, v.vld, v.last, v.mrdy, v.dat);
    #1;
    chk("m_tvalid", idx, 32'(m_tvalid), 32'(v.e_mv));
    chk("s_tready", idx, 32'(s_tready), 32'(v.e_srdy));
    chk("grant_idx", idx, 32'(grant_idx), 32'(v.e_gnt));
    chk("busy", idx, 32'(busy), 32'(v.e_busy));
    if (v.e_mv) begin
      chk("m_tlast", idx, 32'(m_tlast), 32'(v.e_last));
      chk("m_tdata", idx, m_tdata, {16'h0, 8'(v.e_gnt), v.dat});
      chk("m_tid", idx, 32'(m_tid), 32'(v.e_gnt));
    end
    @(negedge ACLK);
  endtask

  initial begin
    int prev;
    int s;
    for (int i = 0; i < 4; i++) begin
      s_tdata[i] = '0; s_tstrb[i] = 4'hf; s_tkeep[i] = 4'hf;
      s_tid[i] = 4'(i); s_tdest[i] = 4'(3 - i); s_tuser[i] = 4'h0;
    end

    // Reset held with every source requesting: nothing may leak through
    s_tvalid = 4'b1111;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    chk("rst_m_tvalid", -1, 32'(m_tvalid), 32'd0);
    chk("rst_s_tready", -1, 32'(s_tready), 32'd0);
    chk("rst_grant_idx", -1, 32'(grant_idx), 32'd0);
    chk("rst_busy", -1, 32'(busy), 32'd0);
    @(negedge ACLK);

    // Single source src2, three beats
    add(0, 4'b0100, 4'b0000, 1, 8'hA1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 1, 8'hA1, 1, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0000, 1, 8'hA2, 1, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 1, 8'hA3, 1, 4'b0100, 2, 1, 1);
    add(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 4'b0000, 2, 0, 0);
    // Wrap: rr_ptr=3 with src3 and src0 requesting
    add(0, 4'b1001, 4'b1001, 1, 8'hB0, 0, 4'b0000, 2, 0, 0);
    add(0, 4'b1001, 4'b1001, 1, 8'hB0, 1, 4'b1000, 3, 1, 1);
    add(0, 4'b0001, 4'b0001, 1, 8'hB1, 0, 4'b0000, 3, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 8'hB1, 1, 4'b0001, 0, 1, 1);
    add(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 4'b0000, 0, 0, 0);
    // Reset mid-packet from src1; afterwards rr_ptr=0 picks src0 first
    add(0, 4'b0010, 4'b0000, 1, 8'hC0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 4'b0000, 1, 8'hC0, 1, 4'b0010, 1, 1, 0);
    add(1, 4'b0011, 4'b0000, 1, 8'hC1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 4'b0001, 1, 8'hC1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 4'b0001, 1, 8'hC2, 1, 4'b0001, 0, 1, 1);
    add(0, 4'b0010, 4'b0000, 1, 8'hC3, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0010, 4'b0010, 1, 8'hC3, 1, 4'b0010, 1, 1, 1);
    add(1, 4'b0000, 4'b0000, 1, 8'h00, 0, 4'b0000, 0, 0, 0);
    // Fairness: all valid, 2-beat packets, grant order 0,1,2,3,0
    prev = 0;
    for (int p = 0; p < 5; p++) begin
      s = p % 4;
      add(0, 4'b1111, 4'b0000, 1, 8'(8'h10 + 2 * p), 0, 4'b0000, 2'(prev), 0, 0);
      add(0, 4'b1111, 4'b0000, 1, 8'(8'h10 + 2 * p), 1, 4'(1 << s), 2'(s), 1, 0);
      add(0, 4'b1111, 4'b1111, 1, 8'(8'h11 + 2 * p), 1, 4'(1 << s), 2'(s), 1, 1);
      prev = s;
    end
    // Backpressure on src1 for 5 cycles with src0 and src3 waiting
    add(0, 4'b1011, 4'b0000, 1, 8'h30, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1011, 4'b0000, 1, 8'h30, 1, 4'b0010, 1, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 4'b1011, 4'b0000, 0, 8'h31, 1, 4'b0000, 1, 1, 0);
    add(0, 4'b1011, 4'b1011, 1, 8'h31, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b1011, 4'b0000, 1, 8'h32, 0, 4'b0000, 1, 0, 0);
    add(0, 4'b1011, 4'b1011, 1, 8'h32, 1, 4'b1000, 3, 1, 1);
    add(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 4'b0000, 3, 0, 0);
    // Source bubble: src0 drops TVALID for 2 cycles, src1 waits for TLAST
    add(0, 4'b0011, 4'b0000, 1, 8'h40, 0, 4'b0000, 3, 0, 0);
    add(0, 4'b0011, 4'b0000, 1, 8'h40, 1, 4'b0001, 0, 1, 0);
    add(0, 4'b0010, 4'b0000, 1, 8'h41, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0010, 4'b0000, 1, 8'h41, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0011, 4'b0001, 1, 8'h41, 1, 4'b0001, 0, 1, 1);
    add(0, 4'b0010, 4'b0000, 1, 8'h42, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0010, 4'b0010, 1, 8'h42, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 4'b0000, 1, 0, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Per-beat arbitration instance: src0/src1 without TLAST alternate beat by beat
    drive(1, 4'b0000, 4'b0000, 1, 8'h00);
    @(negedge ACLK);
    for (int c = 0; c < 8; c++) begin
      drive(0, 4'b0011, 4'b0000, 1, 8'(8'h50 + c));
      #1;
      chk("beat_m_tvalid", 100 + c, 32'(m2_tvalid), 32'(c % 2));
      if (c % 2 == 1) begin
        chk("beat_grant", 100 + c, 32'(grant2_idx), 32'(((c - 1) / 2) % 2));
        chk("beat_s_tready", 100 + c, 32'(s2_tready), 32'(1 << (((c - 1) / 2) % 2)));
        chk("beat_m_tdata", 100 + c, m2_tdata, {16'h0, 8'(((c - 1) / 2) % 2), 8'(8'h50 + c)});
      end
      @(negedge ACLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
